// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: sums a WIDTH-bit pair DIGIT bits per clock, LSD first,
// with a start/ready/done handshake plus carry-out and signed-overflow flags.
module serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);
  localparam logic [WIDTH-1:0] DIG_MASK = WIDTH'({DIGIT{1'b1}});

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;     // operand B already inverted for subtraction
  logic             carry_q, carry_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  int               off;
  logic [DIGIT-1:0] a_dig, b_dig;
  logic [DIGIT:0]   dig_sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      sum_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    k_d     = k_q;
    sum_d   = sum_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    off     = int'(k_q) * DIGIT;
    a_dig   = DIGIT'(a_q >> off);
    b_dig   = DIGIT'(b_q >> off);
    dig_sum = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = (sum_q & ~(DIG_MASK << off)) | (WIDTH'(dig_sum[DIGIT-1:0]) << off);
        carry_d = dig_sum[DIGIT];
        k_d     = k_q + 1'b1;
        if (k_q == K_LAST) begin
          s_d     = sum_d;
          cout_d  = dig_sum[DIGIT];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign s     = s_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: a 16-bit/4-bit-digit instance for directed cases
// and a 4-bit bit-serial instance checked exhaustively against an integer model.
module tb_serial_addsub;

  typedef struct {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start16 = 1'b0, sub16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        ready16, busy16, done16, cout16, ovf16;
  logic [15:0] s16;

  logic        start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        ready4, busy4, done4, cout4, ovf4;
  logic [3:0]  s4;

  int checks = 0;
  int failures = 0;
  int done16_cnt = 0;
  exp_t sb16[$];
  exp_t sb4[$];

  serial_addsub #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .cin(cin16),
    .a(a16), .b(b16), .ready(ready16), .busy(busy16), .done(done16),
    .s(s16), .cout(cout16), .ovf(ovf16)
  );

  serial_addsub #(.WIDTH(4), .DIGIT(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .cin(cin4),
    .a(a4), .b(b4), .ready(ready4), .busy(busy4), .done(done4),
    .s(s4), .cout(cout4), .ovf(ovf4)
  );

  always @(posedge clk) if (done16 === 1'b1) done16_cnt <= done16_cnt + 1;

  // Reference: unsigned sum for s/cout, true signed arithmetic for overflow.
  function automatic exp_t model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                 input logic cv, input logic sv);
    exp_t e;
    longint mask, ua, ub, full, sa, sb, r, half;
    mask = (64'd1 << w) - 1;
    half = 64'd1 << (w - 1);
    ua = longint'(av) & mask;
    ub = longint'(bv) & mask;
    full = sv ? (ua + ((~ub) & mask) + 1) : (ua + ub + longint'(cv));
    e.s = 16'(full & mask);
    e.cout = full[w];
    sa = (ua >= half) ? ua - (mask + 1) : ua;
    sb = (ub >= half) ? ub - (mask + 1) : ub;
    r = sv ? (sa - sb) : (sa + sb + longint'(cv));
    e.ovf = (r < -half) || (r > half - 1);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_op16(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                         input logic sv, input string name);
    exp_t e;
    int lat;
    sb16.push_back(model(16, av, bv, cv, sv));
    a16 = av; b16 = bv; cin16 = cv; sub16 = sv; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    lat = 0;
    while (done16 !== 1'b1 && lat < 20) begin tick(); lat++; end
    e = sb16.pop_front();
    checks++;
    if (lat != 4) begin
      failures++;
      $display("FAIL %s latency got=%0d want=4", name, lat);
    end
    checks++;
    if (s16 !== e.s || cout16 !== e.cout || ovf16 !== e.ovf) begin
      failures++;
      $display("FAIL %s result got s=%h cout=%b ovf=%b want s=%h cout=%b ovf=%b",
               name, s16, cout16, ovf16, e.s, e.cout, e.ovf);
    end
    checks++;
    if (ready16 !== 1'b0) begin
      failures++;
      $display("FAIL %s ready_in_done got=%b want=0", name, ready16);
    end
    tick();
    checks++;
    if (ready16 !== 1'b1 || done16 !== 1'b0) begin
      failures++;
      $display("FAIL %s ready_after got ready=%b done=%b want ready=1 done=0", name, ready16, done16);
    end
    $display("op %s a=%h b=%h cin=%b sub=%b -> s=%h cout=%b ovf=%b", name, av, bv, cv, sv,
             s16, cout16, ovf16);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    checks++;
    if (ready16 !== 1'b1 || busy16 !== 1'b0 || done16 !== 1'b0 || s16 !== 16'h0 ||
        cout16 !== 1'b0 || ovf16 !== 1'b0) begin
      failures++;
      $display("FAIL reset16 got r=%b b=%b d=%b s=%h c=%b o=%b want 1 0 0 0000 0 0",
               ready16, busy16, done16, s16, cout16, ovf16);
    end
    checks++;
    if (ready4 !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b0 || s4 !== 4'h0 ||
        cout4 !== 1'b0 || ovf4 !== 1'b0) begin
      failures++;
      $display("FAIL reset4 got r=%b b=%b d=%b s=%h c=%b o=%b want 1 0 0 0 0 0",
               ready4, busy4, done4, s4, cout4, ovf4);
    end
  endtask

  task automatic test_add();
    do_op16(16'h1234, 16'h4321, 1'b0, 1'b0, "add_basic");
    do_op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, "add_carry");
    do_op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, "add_ovf");
    do_op16(16'h0000, 16'h0000, 1'b1, 1'b0, "add_cin");
    do_op16(16'h8000, 16'h8000, 1'b1, 1'b0, "add_negovf");
  endtask

  task automatic test_sub();
    do_op16(16'h0005, 16'h0007, 1'b1, 1'b1, "sub_borrow");
    do_op16(16'h8000, 16'h0001, 1'b0, 1'b1, "sub_ovf");
    do_op16(16'h1234, 16'h1234, 1'b0, 1'b1, "sub_zero");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      do_op16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "b2b_rand");
  endtask

  task automatic test_ignore_start();
    exp_t e;
    int lat, cnt0;
    cnt0 = done16_cnt;
    sb16.push_back(model(16, 16'h0F0F, 16'h1111, 1'b1, 1'b0));
    a16 = 16'h0F0F; b16 = 16'h1111; cin16 = 1'b1; sub16 = 1'b0; start16 = 1'b1;
    tick();
    a16 = 16'hAAAA; b16 = 16'h5555; sub16 = 1'b1; cin16 = 1'b0;
    lat = 0;
    while (done16 !== 1'b1 && lat < 20) begin tick(); lat++; end
    e = sb16.pop_front();
    checks++;
    if (lat != 4 || s16 !== e.s || cout16 !== e.cout || ovf16 !== e.ovf) begin
      failures++;
      $display("FAIL ignore_run got lat=%0d s=%h c=%b o=%b want lat=4 s=%h c=%b o=%b",
               lat, s16, cout16, ovf16, e.s, e.cout, e.ovf);
    end
    tick();
    start16 = 1'b0;
    checks++;
    if (ready16 !== 1'b1) begin
      failures++;
      $display("FAIL ignore_done ready got=%b want=1", ready16);
    end
    tick(); tick(); tick();
    checks++;
    if (busy16 !== 1'b0 || done16_cnt != cnt0 + 1 || s16 !== e.s) begin
      failures++;
      $display("FAIL ignore_after got busy=%b pulses=%0d s=%h want busy=0 pulses=1 s=%h",
               busy16, done16_cnt - cnt0, s16, e.s);
    end
    $display("op ignore_start a=0f0f b=1111 cin=1 sub=0 -> s=%h cout=%b ovf=%b", s16, cout16, ovf16);
  endtask

  task automatic test_reset_abort();
    int cnt0;
    cnt0 = done16_cnt;
    a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; sub16 = 1'b0; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (ready16 !== 1'b1 || busy16 !== 1'b0 || s16 !== 16'h0 || cout16 !== 1'b0 || ovf16 !== 1'b0) begin
      failures++;
      $display("FAIL abort_state got r=%b b=%b s=%h c=%b o=%b want 1 0 0000 0 0",
               ready16, busy16, s16, cout16, ovf16);
    end
    repeat (6) tick();
    checks++;
    if (done16_cnt != cnt0) begin
      failures++;
      $display("FAIL abort_nodone got pulses=%0d want=0", done16_cnt - cnt0);
    end
    $display("op abort a=1111 b=2222 -> reset mid-RUN");
    do_op16(16'hABCD, 16'h1357, 1'b0, 1'b1, "after_abort");
  endtask

  task automatic test_exhaustive4();
    exp_t e;
    int lat, bad;
    for (int sv = 0; sv < 2; sv++) begin
      for (int cv = 0; cv < 2; cv++) begin
        bad = 0;
        for (int av = 0; av < 16; av++) begin
          for (int bv = 0; bv < 16; bv++) begin
            sb4.push_back(model(4, 16'(av), 16'(bv), 1'(cv), 1'(sv)));
            a4 = 4'(av); b4 = 4'(bv); cin4 = 1'(cv); sub4 = 1'(sv); start4 = 1'b1;
            tick();
            start4 = 1'b0;
            lat = 0;
            while (done4 !== 1'b1 && lat < 20) begin tick(); lat++; end
            e = sb4.pop_front();
            checks++;
            if (lat != 4 || s4 !== e.s[3:0] || cout4 !== e.cout || ovf4 !== e.ovf) begin
              failures++;
              bad++;
              $display("FAIL exh4 a=%h b=%h cin=%0d sub=%0d got lat=%0d s=%h c=%b o=%b want lat=4 s=%h c=%b o=%b",
                       av, bv, cv, sv, lat, s4, cout4, ovf4, e.s[3:0], e.cout, e.ovf);
            end
            tick();
          end
        end
        $display("op exhaustive4 sub=%0d cin=%0d cases=256 bad=%0d", sv, cv, bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    test_exhaustive4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
